// File: rtl/ram64_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram64_pkg
// Purpose  : Shared defaults and the FSM state type for the ram64 write
//            arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ram64_pkg;

    localparam int c_DATA_W = 16;
    localparam int c_ADDR_W = 3;
    localparam int c_DEPTH  = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin grant. A lone requester always wins; on a
//            tie, the requester that did not win last time is granted.
// Ports    : req[1:0] - request vector
//            last     - index of the requester granted last
//            gnt[1:0] - one-hot (or zero) grant vector
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | last);
        gnt[1] = req[1] & (~req[0] | ~last);
    end

endmodule
`default_nettype wire

// File: rtl/ram64_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : ram64_wr_arb
// Purpose  : Arbitrates two write requesters onto one RAM write port and
//            provides a clear sweep that zeroes all DEPTH words.
// Ports    : clk, reset               - clock, synchronous active-high reset
//            m0_valid/addr/data/ready - requester 0 write handshake
//            m1_valid/addr/data/ready - requester 1 write handshake
//            clr_start                - request a clear sweep
//            clr_busy / clr_done      - sweep in progress / completion pulse
//            ram_wr/ram_wr_addr/ram_d_in - registered RAM write port
// Revision : 1.0 - initial release
// ============================================================================
module ram64_wr_arb
    import ram64_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W,
    parameter int DEPTH  = c_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_valid,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_data,
    output logic              m0_ready,
    input  logic              m1_valid,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_data,
    output logic              m1_ready,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_d_in
);

    localparam logic [ADDR_W-1:0] c_CNT_LAST = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_grant;
    logic [ADDR_W-1:0] r_cnt;
    logic [1:0]        w_gnt;
    logic              w_last_clr;
    logic              w_xfer;
    logic              r_ram_wr;
    logic [ADDR_W-1:0] r_ram_wr_addr;
    logic [DATA_W-1:0] r_ram_d_in;
    logic              r_clr_done;

    rr_arb2 u_arb (
        .req  ({m1_valid, m0_valid}),
        .last (r_last_grant),
        .gnt  (w_gnt)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and combinational outputs. Readies come straight from the
    // grant so a requester can transfer in the same cycle it asks.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        clr_busy    = 1'b0;
        w_last_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                m0_ready = w_gnt[0];
                m1_ready = w_gnt[1];
                if (clr_start) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                if (r_cnt == c_CNT_LAST) begin
                    w_last_clr  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_xfer = m0_ready | m1_ready;

    // ------------------------------------------------------------------
    // Datapath: the write port is registered, so both transfers and clear
    // words appear one cycle after they are decided. A transfer accepted
    // alongside clr_start therefore lands ahead of clear word 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant  <= 1'b1;
            r_cnt         <= '0;
            r_ram_wr      <= 1'b0;
            r_ram_wr_addr <= '0;
            r_ram_d_in    <= '0;
            r_clr_done    <= 1'b0;
        end else begin
            r_clr_done <= w_last_clr;
            r_ram_wr   <= 1'b0;
            if (w_xfer) begin
                r_last_grant  <= m1_ready;
                r_ram_wr      <= 1'b1;
                r_ram_wr_addr <= m1_ready ? m1_addr : m0_addr;
                r_ram_d_in    <= m1_ready ? m1_data : m0_data;
            end else if (r_state == CLEAR) begin
                r_ram_wr      <= 1'b1;
                r_ram_wr_addr <= r_cnt;
                r_ram_d_in    <= '0;
            end
            if (r_state == IDLE && clr_start) begin
                r_cnt <= '0;
            end else if (r_state == CLEAR) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign ram_wr      = r_ram_wr;
    assign ram_wr_addr = r_ram_wr_addr;
    assign ram_d_in    = r_ram_d_in;
    assign clr_done    = r_clr_done;

endmodule
`default_nettype wire
